// File: rtl/param_assoc_cache_pkg.sv
// Shared definitions for the set-associative cache: request opcodes, controller
// states and a constant-foldable log2 helper used for derived widths.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_WRITE  = 2'd1,
        OP_FILL   = 2'd2,
        OP_FLUSH  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Ceiling log2; clog2(1)=0, clog2(2)=1, clog2(3)=2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/param_assoc_cache_if.sv
// Request/response bundle between a cache client (master) and the cache (slave).
interface param_assoc_cache_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int WAYS   = 2,
    parameter int SETS   = 32
);
    localparam int IDX_W = cache_pkg::clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = cache_pkg::clog2(WAYS);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_dirty;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [DATA_W-1:0] rsp_data;
    logic [WAY_W-1:0]  rsp_way;
    logic              vic_valid;
    logic [TAG_W-1:0]  vic_tag;
    logic [DATA_W-1:0] vic_data;
    logic              busy;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_dirty,
        input  req_ready, rsp_valid, rsp_hit, rsp_data, rsp_way,
               vic_valid, vic_tag, vic_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_dirty,
        output req_ready, rsp_valid, rsp_hit, rsp_data, rsp_way,
               vic_valid, vic_tag, vic_data, busy
    );

endinterface

// File: rtl/param_assoc_cache_plru_tree.sv
// Tree pseudo-LRU for one set. Node n (heap order, root=1) lives in tree[n-1];
// a node bit names the child that is least recently used (0=left, 1=right).
module plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-2:0]  tree,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAYS-2:0]  tree_next,
    output logic [WAY_W-1:0] victim
);
    // Leaf number of the accessed way in heap order, and the tree padded so
    // that a heap node number indexes it directly.
    logic [WAY_W:0]    access_leaf;
    logic [2*WAYS-1:0] tree_heap;

    assign access_leaf = {1'b1, access_way};
    assign tree_heap   = {{WAYS{1'b0}}, tree, 1'b0};

    // Each node on the accessed way's path points away from it; others keep state.
    generate
        for (genvar gi = 1; gi < WAYS; gi++) begin : g_node
            localparam int LEVEL = clog2(gi + 1) - 1;
            assign tree_next[gi-1] =
                ((access_leaf >> (WAY_W - LEVEL)) == (WAY_W+1)'(gi)) ?
                ~access_way[WAY_W-1-LEVEL] : tree[gi-1];
        end
    endgenerate

    // Walk from the root following the LRU pointers down to a leaf.
    always_comb begin
        logic [WAY_W:0] node;
        node = (WAY_W+1)'(1);
        for (int l = 0; l < WAY_W; l++) begin
            node = {node[WAY_W-1:0], tree_heap[node]};
        end
        victim = node[WAY_W-1:0];
    end

endmodule

// File: rtl/param_assoc_cache.sv
// Parameterised set-associative cache tag/data array with tree PLRU replacement.
// A request is looked up and committed on its acceptance edge; the response,
// describing the array state before that commit, is presented the next cycle.
// Optional macro CACHE_STATS_EN adds saturating LOOKUP hit/miss counters.
module param_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int WAYS   = 2,
    parameter int SETS   = 32
) (
    input  logic clk,
    input  logic rst_n,
    param_assoc_cache_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int IDX_W  = clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam int WAY_W  = clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;

    state_e            state_reg, state_next;
    logic [IDX_W-1:0]  flush_cnt_reg;

    // Status bits need clearing on reset/flush; tags and data do not.
    logic [WAYS-1:0]   valid_reg [SETS];
    logic [WAYS-1:0]   dirty_reg [SETS];
    logic [PLRU_W-1:0] plru_reg  [SETS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [DATA_W-1:0] data_mem  [SETS][WAYS];

    logic              rsp_hit_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic [WAY_W-1:0]  rsp_way_reg;
    logic              vic_valid_reg;
    logic [TAG_W-1:0]  vic_tag_reg;
    logic [DATA_W-1:0] vic_data_reg;

    op_e               req_op;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              accept;
    logic              ready_int, rsp_valid_int, busy_int;

    assign req_op  = op_e'(bus.req_op);
    assign req_idx = bus.req_addr[IDX_W-1:0];
    assign req_tag = bus.req_addr[ADDR_W-1:IDX_W];
    assign accept  = bus.req_valid && ready_int;

    // Per-way view of the addressed set.
    logic [WAYS-1:0]   hit_vec;
    logic [WAYS-1:0]   set_valid, set_dirty;
    logic [TAG_W-1:0]  set_tag  [WAYS];
    logic [DATA_W-1:0] set_data [WAYS];

    assign set_valid = valid_reg[req_idx];
    assign set_dirty = dirty_reg[req_idx];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign set_tag[gi]  = tag_mem[req_idx][gi];
            assign set_data[gi] = data_mem[req_idx][gi];
            assign hit_vec[gi]  = set_valid[gi] && (set_tag[gi] == req_tag);
        end
    endgenerate

    logic             hit_any, inv_any;
    logic [WAY_W-1:0] hit_way, inv_way, plru_victim, victim_way, acc_way;
    logic [PLRU_W-1:0] plru_next;
    logic             vic_line_valid, vic_line_dirty;
    logic             do_write, do_plru;

    // Encode the hit way and the lowest-numbered invalid way.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                inv_way = WAY_W'(w);
            end
        end
    end

    assign hit_any        = |hit_vec;
    assign inv_any        = ~&set_valid;
    assign victim_way     = inv_any ? inv_way : plru_victim;
    assign acc_way        = hit_any ? hit_way : victim_way;
    assign vic_line_valid = set_valid[victim_way];
    assign vic_line_dirty = set_dirty[victim_way];

    assign do_write = accept && ((req_op == OP_WRITE && hit_any) || req_op == OP_FILL);
    assign do_plru  = do_write || (accept && req_op == OP_LOOKUP && hit_any);

    plru_tree #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_plru (
        .tree       (plru_reg[req_idx]),
        .access_way (acc_way),
        .tree_next  (plru_next),
        .victim     (plru_victim)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        ready_int     = 1'b0;
        rsp_valid_int = 1'b0;
        busy_int      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (bus.req_valid) begin
                    state_next = (req_op == OP_FLUSH) ? ST_FLUSH : ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_int = 1'b1;
                state_next    = ST_IDLE;
            end
            ST_FLUSH: begin
                busy_int = 1'b1;
                if (flush_cnt_reg == IDX_W'(SETS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Flush sweep pointer; wraps back to 0 on the last set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_reg <= '0;
        end else if (state_reg == ST_FLUSH) begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    // Valid/dirty/PLRU status: cleared per set while flushing, else updated by requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                plru_reg[s]  <= '0;
            end
        end else if (state_reg == ST_FLUSH) begin
            valid_reg[flush_cnt_reg] <= '0;
            dirty_reg[flush_cnt_reg] <= '0;
            plru_reg[flush_cnt_reg]  <= '0;
        end else begin
            if (do_write) begin
                valid_reg[req_idx][acc_way] <= 1'b1;
                dirty_reg[req_idx][acc_way] <= bus.req_dirty;
            end
            if (do_plru) begin
                plru_reg[req_idx] <= plru_next;
            end
        end
    end

    // Tag and data storage.
    always_ff @(posedge clk) begin
        if (do_write) begin
            tag_mem[req_idx][acc_way]  <= req_tag;
            data_mem[req_idx][acc_way] <= bus.req_wdata;
        end
    end

    // Response capture on acceptance; holds until the next non-flush request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_hit_reg   <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_way_reg   <= '0;
            vic_valid_reg <= 1'b0;
            vic_tag_reg   <= '0;
            vic_data_reg  <= '0;
        end else if (accept && req_op != OP_FLUSH) begin
            rsp_hit_reg   <= hit_any;
            rsp_data_reg  <= hit_any ? set_data[hit_way] : '0;
            rsp_way_reg   <= acc_way;
            vic_valid_reg <= !hit_any && vic_line_valid && vic_line_dirty;
            vic_tag_reg   <= (!hit_any && vic_line_valid) ? set_tag[victim_way] : '0;
            vic_data_reg  <= (!hit_any && vic_line_valid) ? set_data[victim_way] : '0;
        end
    end

    assign bus.req_ready = ready_int;
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.busy      = busy_int;
    assign bus.rsp_hit   = rsp_hit_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_way   = rsp_way_reg;
    assign bus.vic_valid = vic_valid_reg;
    assign bus.vic_tag   = vic_tag_reg;
    assign bus.vic_data  = vic_data_reg;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    // Saturating LOOKUP outcome counters, zeroed when a flush is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (accept && req_op == OP_FLUSH) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (accept && req_op == OP_LOOKUP) begin
            if (hit_any) begin
                if (hit_cnt_reg != '1) begin
                    hit_cnt_reg <= hit_cnt_reg + 1'b1;
                end
            end else if (miss_cnt_reg != '1) begin
                miss_cnt_reg <= miss_cnt_reg + 1'b1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_param_assoc_cache.sv
// Directed bench for param_assoc_cache (default parameters: 2 ways, 32 sets).
// Set 5 addresses: tag t -> (t << 5) | 5.
module tb_param_assoc_cache;
    import cache_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;
    localparam int WAYS   = 2;
    localparam int SETS   = 32;
    localparam int NVEC   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    param_assoc_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    param_assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [13:0] addr;
        logic [63:0] wdata;
        logic        dirty;
        logic        hit;
        logic [63:0] data;
        logic        way;
        logic        vv;
        logic [8:0]  vtag;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request after the cache is ready; returns at the response cycle.
    task automatic issue(input logic [1:0] op, input logic [13:0] addr,
                         input logic [63:0] wdata, input logic dirty);
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!bus.req_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.req_ready) check("ready_timeout", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_dirty = dirty;
        @(negedge clk);
        bus.req_valid = 1'b0;
        $display("[TB] txn op=%0d addr=0x%04h rsp_valid=%0d hit=%0d way=%0d data=0x%0h vic=%0d tag=0x%0h busy=%0d",
                 op, addr, bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_data,
                 bus.vic_valid, bus.vic_tag, bus.busy);
    endtask

    task automatic lookup_expect(input string name, input logic [13:0] addr, input logic exp_hit);
        issue(OP_LOOKUP, addr, 64'h0, 1'b0);
        check({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
        check({name, "_hit"}, 64'(bus.rsp_hit), 64'(exp_hit));
    endtask

    // Issue a flush and measure how long busy stays up.
    task automatic flush_expect(input string name);
        int busy_cycles;
        int ready_bad;
        int rsp_seen;
        busy_cycles = 0;
        ready_bad   = 0;
        rsp_seen    = 0;
        issue(OP_FLUSH, 14'h0, 64'h0, 1'b0);
        while (bus.busy && busy_cycles < 100) begin
            if (bus.req_ready) ready_bad++;
            if (bus.rsp_valid) rsp_seen++;
            busy_cycles++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(SETS));
        check({name, "_ready_low"}, 64'(ready_bad), 64'd0);
        check({name, "_no_rsp"}, 64'(rsp_seen), 64'd0);
        check({name, "_ready_after"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        int seen;

        vecs[0]  = '{OP_LOOKUP, 14'h0025, 64'h0,        1'b0, 1'b0, 64'h0,        1'b0, 1'b0, 9'h000};
        vecs[1]  = '{OP_FILL,   14'h0025, 64'hA5A5,     1'b0, 1'b0, 64'h0,        1'b0, 1'b0, 9'h000};
        vecs[2]  = '{OP_LOOKUP, 14'h0025, 64'h0,        1'b0, 1'b1, 64'hA5A5,     1'b0, 1'b0, 9'h000};
        vecs[3]  = '{OP_FILL,   14'h0025, 64'h1111,     1'b1, 1'b1, 64'h0,        1'b0, 1'b0, 9'h000};
        vecs[4]  = '{OP_FILL,   14'h0045, 64'h2222,     1'b1, 1'b0, 64'h0,        1'b1, 1'b0, 9'h000};
        vecs[5]  = '{OP_LOOKUP, 14'h0025, 64'h0,        1'b0, 1'b1, 64'h1111,     1'b0, 1'b0, 9'h000};
        vecs[6]  = '{OP_FILL,   14'h0065, 64'h3333,     1'b0, 1'b0, 64'h0,        1'b1, 1'b1, 9'h002};
        vecs[7]  = '{OP_LOOKUP, 14'h0045, 64'h0,        1'b0, 1'b0, 64'h0,        1'b0, 1'b1, 9'h001};
        vecs[8]  = '{OP_LOOKUP, 14'h0065, 64'h0,        1'b0, 1'b1, 64'h3333,     1'b1, 1'b0, 9'h000};
        vecs[9]  = '{OP_WRITE,  14'h0065, 64'h4444,     1'b1, 1'b1, 64'h0,        1'b1, 1'b0, 9'h000};
        vecs[10] = '{OP_LOOKUP, 14'h0065, 64'h0,        1'b0, 1'b1, 64'h4444,     1'b1, 1'b0, 9'h000};
        vecs[11] = '{OP_WRITE,  14'h0085, 64'h5555,     1'b1, 1'b0, 64'h0,        1'b0, 1'b1, 9'h001};
        vecs[12] = '{OP_LOOKUP, 14'h0085, 64'h0,        1'b0, 1'b0, 64'h0,        1'b0, 1'b1, 9'h001};
        vecs[13] = '{OP_LOOKUP, 14'h3FFF, 64'h0,        1'b0, 1'b0, 64'h0,        1'b0, 1'b0, 9'h000};
        vecs[14] = '{OP_FILL,   14'h3FFF, 64'hDEADBEEF, 1'b1, 1'b0, 64'h0,        1'b0, 1'b0, 9'h000};
        vecs[15] = '{OP_LOOKUP, 14'h3FFF, 64'h0,        1'b0, 1'b1, 64'hDEADBEEF, 1'b0, 1'b0, 9'h000};

        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_dirty = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_vic_valid", 64'(bus.vic_valid), 64'd0);
        check("rst_vic_tag", 64'(bus.vic_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd1);

        // Table-driven request/response vectors.
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].dirty);
            check($sformatf("v%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("v%0d_hit", i), 64'(bus.rsp_hit), 64'(vecs[i].hit));
            check($sformatf("v%0d_way", i), 64'(bus.rsp_way), 64'(vecs[i].way));
            check($sformatf("v%0d_vic_valid", i), 64'(bus.vic_valid), 64'(vecs[i].vv));
            check($sformatf("v%0d_vic_tag", i), 64'(bus.vic_tag), 64'(vecs[i].vtag));
            if (vecs[i].op == OP_LOOKUP) begin
                check($sformatf("v%0d_data", i), bus.rsp_data, vecs[i].data);
            end
        end

        // Flush sweep, then previously filled lines must miss.
        flush_expect("flush1");
        lookup_expect("post_flush_25", 14'h0025, 1'b0);
        lookup_expect("post_flush_65", 14'h0065, 1'b0);
        lookup_expect("post_flush_3fff", 14'h3FFF, 1'b0);

        // Response hold, then reset arriving in the response cycle.
        issue(OP_FILL, 14'h0025, 64'hA5A5, 1'b0);
        lookup_expect("refill_25", 14'h0025, 1'b1);
        check("refill_25_data", bus.rsp_data, 64'hA5A5);
        @(negedge clk);
        check("hold_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("hold_rsp_hit", 64'(bus.rsp_hit), 64'd1);
        check("hold_rsp_data", bus.rsp_data, 64'hA5A5);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_FILL;
        bus.req_addr  = 14'h0045;
        bus.req_wdata = 64'h7777;
        bus.req_dirty = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("abort_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        check("abort_rsp_data", bus.rsp_data, 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("abort_no_rsp", 64'(seen), 64'd0);
        check("abort_ready", 64'(bus.req_ready), 64'd1);
        lookup_expect("abort_lookup_25", 14'h0025, 1'b0);
        lookup_expect("abort_lookup_45", 14'h0045, 1'b0);

`ifdef CACHE_STATS_EN
        // LOOKUP statistics: 3 hits, 2 misses, then cleared by flush.
        flush_expect("stats_flush0");
        check("stats_hit_zero0", 64'(hit_cnt), 64'd0);
        check("stats_miss_zero0", 64'(miss_cnt), 64'd0);
        issue(OP_FILL, 14'h0025, 64'hBEEF, 1'b0);
        lookup_expect("stats_h1", 14'h0025, 1'b1);
        lookup_expect("stats_h2", 14'h0025, 1'b1);
        lookup_expect("stats_h3", 14'h0025, 1'b1);
        lookup_expect("stats_m1", 14'h0045, 1'b0);
        lookup_expect("stats_m2", 14'h0065, 1'b0);
        check("stats_hit_cnt", 64'(hit_cnt), 64'd3);
        check("stats_miss_cnt", 64'(miss_cnt), 64'd2);
        flush_expect("stats_flush1");
        check("stats_hit_zero1", 64'(hit_cnt), 64'd0);
        check("stats_miss_zero1", 64'(miss_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
